// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetcher with a small FIFO of
// {instruction, PC+4} entries presented to decode over valid/ready.
// At most one memory request is outstanding at a time. The FIFO slot for a
// fetch is reserved when the request is made, so a push can never overflow.
// A redirect clears the FIFO and restarts fetch at the new PC. A response
// that belongs to a squashed fetch is discarded.
// Optional build macro: PREFETCH_BYPASS_EN. When it is defined, a response
// that arrives while the FIFO is empty and decode is ready is forwarded
// straight to the decode outputs in the same cycle.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_plus_4_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DROP      = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt;
  // Held low for one cycle after reset so no request issues in the reset cycle
  logic             fetch_en;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic             fifo_full;
  logic             fifo_nonempty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic [31:0]      redirect_pc_aligned;

  assign fifo_full           = (count == DEPTH_C);
  assign fifo_nonempty       = (count != '0);
  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};
  assign mem_addr_o          = fetch_pc;
  assign occupancy_o         = count;

  // Fetch state register and fetch PC
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      fetch_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      fetch_en <= 1'b1;
    end
  end

  // Fetch FSM: request issue, response capture, squash tracking
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_req_o    = 1'b0;
    push         = 1'b0;
    bypass       = 1'b0;
    case (state)
      IDLE: begin
        mem_req_o = fetch_en && !fifo_full;
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc_aligned;
          // An ack in the redirect cycle still leaves a response in flight
          if (mem_req_o && mem_ack_i) begin
            state_nxt = DROP;
          end
        end else if (mem_req_o && mem_ack_i) begin
          state_nxt    = WAIT_RESP;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      WAIT_RESP: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc_aligned;
          state_nxt    = mem_rvalid_i ? IDLE : DROP;
        end else if (mem_rvalid_i) begin
          state_nxt = IDLE;
`ifdef PREFETCH_BYPASS_EN
          if (!fifo_nonempty && instr_ready_i) begin
            bypass = 1'b1;
          end else begin
            push = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end
      end
      DROP: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc_aligned;
        end
        // The squashed response is consumed here; a redirect does not
        // create a second outstanding request, so rvalid always ends DROP.
        if (mem_rvalid_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Decode-side outputs: FIFO head, or the bypassed response when enabled
  always_comb begin
    pop = fifo_nonempty && instr_ready_i && !redirect_i;
`ifdef PREFETCH_BYPASS_EN
    instr_valid_o = fifo_nonempty || bypass;
    if (bypass) begin
      instr_o     = mem_rdata_i;
      pc_plus_4_o = fetch_pc;
    end else if (fifo_nonempty) begin
      instr_o     = instr_mem[rd_ptr];
      pc_plus_4_o = pc_mem[rd_ptr];
    end else begin
      instr_o     = '0;
      pc_plus_4_o = '0;
    end
`else
    instr_valid_o = fifo_nonempty;
    if (fifo_nonempty) begin
      instr_o     = instr_mem[rd_ptr];
      pc_plus_4_o = pc_mem[rd_ptr];
    end else begin
      instr_o     = '0;
      pc_plus_4_o = '0;
    end
`endif
  end

  // FIFO pointers and occupancy; redirect empties the queue
  always_ff @(posedge clk) begin
    if (reset || redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; the entry PC+4 is the already-advanced fetch PC
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[wr_ptr] <= mem_rdata_i;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch-side front end between a variable-latency instruction memory and the IF/ID pipeline register.
- Generates sequential word fetch addresses and buffers returned instructions with their PC+4 in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Flushes and restarts from a new PC on branch, jump or jr redirect; late memory responses from squashed fetches are discarded.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0040_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req_o  out  1  fetch request valid.
- mem_addr_o  out  32  fetch word address, bits [1:0] always 0.
- mem_ack_i  in  1  memory accepted request this cycle.
- mem_rvalid_i  in  1  response data valid; in order, at most one per accepted request.
- mem_rdata_i  in  32  instruction word.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  restart address; bits [1:0] ignored and treated as 0.
- instr_valid_o  out  1  head entry valid toward decode.
- instr_o  out  32  head instruction.
- pc_plus_4_o  out  32  PC+4 of head instruction.
- instr_ready_i  in  1  decode accepts head (IF/ID write enable).
- occupancy_o  out  log2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset, sampled on a clk edge: fetch_pc=RESET_PC, FIFO empty, state=IDLE. Outputs: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_plus_4_o=0, occupancy_o=0. Reset overrides every other input, including mid-transaction; any in-flight response is not tracked afterwards.
- At most one outstanding request. States:
  - IDLE: assert mem_req_o when occupancy_o < DEPTH. mem_addr_o=fetch_pc. mem_ack_i=1 -> WAIT_RESP, fetch_pc+=4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - While mem_req_o=1 and not acked, mem_addr_o is held stable. The request is withdrawn only by redirect.
  - WAIT_RESP: mem_req_o=0. On mem_rvalid_i, push {mem_rdata_i, address+4} and go to IDLE. A new request may issue the cycle after the push.
  - DROP: entered on redirect while in WAIT_RESP. The next mem_rvalid_i is discarded, then go to IDLE. No request issues in DROP.
- The slot is reserved at request time, so a push never overflows. mem_rvalid_i outside WAIT_RESP/DROP is ignored.
- Pop: instr_valid_o && instr_ready_i removes the head.
  - Push and pop in the same cycle: occupancy unchanged.
  - Pop on empty is impossible because instr_valid_o=0.
- Latency: mem_rvalid_i in cycle N -> instr_valid_o=1 in cycle N+1 when the FIFO was empty.
- instr_o and pc_plus_4_o are registered from the FIFO head. They hold their value while instr_valid_o=1 and instr_ready_i=0.
- Redirect takes priority over push, pop and ack in the same cycle:
  - FIFO cleared; instr_valid_o=0 the next cycle.
  - fetch_pc=redirect_pc_i & ~3.
  - IDLE with an unacked request: the request is dropped and re-requested at the new PC the next cycle. A mem_ack_i in the redirect cycle counts as accepted -> DROP.
  - WAIT_RESP -> DROP.
  - WAIT_RESP with mem_rvalid_i in the same cycle: data discarded -> IDLE.
  - DROP -> stays DROP.
- Back-to-back redirects: the last one wins.
- The full condition stalls fetch only. The decode side is unaffected.

Optional Feature:
- Macro PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state is WAIT_RESP, mem_rvalid_i=1 and instr_ready_i=1, the response is forwarded combinationally to instr_o/pc_plus_4_o with instr_valid_o=1 in the same cycle and is not pushed. If instr_ready_i=0, the response is pushed normally. Redirect in the same cycle still suppresses the bypass.
- Undefined: all outputs are registered; minimum response-to-valid latency is 1 cycle.

Test Plan:
- Reset, memory acks immediately, responds one cycle later, instr_ready_i=1 -> addresses 0x00400000, 0x00400004, 0x00400008 in order; pc_plus_4_o = 0x00400004, 0x00400008, 0x0040000C.
- instr_ready_i=0 with DEPTH=4 -> exactly 4 pushes, occupancy_o=4, mem_req_o stays 0. Raise ready for one cycle -> one pop, one new request at 0x00400010.
- Redirect to 0x00401003 in WAIT_RESP, rvalid with 0xDEADBEEF two cycles later -> 0xDEADBEEF never appears. Next request is 0x00401000, FIFO empty after redirect.
- Redirect asserted in the same cycle as mem_rvalid_i and a pop -> data dropped, occupancy_o=0 next cycle, state IDLE.
- mem_ack_i held low 5 cycles -> mem_addr_o stable at 0x00400000 throughout. Assert reset mid-wait -> next cycle mem_req_o=0, then a request at RESET_PC.
- With PREFETCH_BYPASS_EN, empty FIFO, ready=1, rvalid data 0x20080005 -> instr_valid_o=1 and instr_o=0x20080005 in the same cycle. Without the macro, the same stimulus gives instr_valid_o=1 one cycle later.
